// File: rtl/shift_rotate_unit_pkg.sv
// Shared definitions for the multi-cycle shift/rotate unit: op codes, FSM encoding
// and the decode helper that folds unused op codes into PASS.
package shift_pkg;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_pass(input logic [2:0] op);
    return (op > OP_SRA);
  endfunction

endpackage

// File: rtl/shift_rotate_unit_if.sv
// Request/response bundle between the control unit and the shift/rotate unit.
interface shift_rotate_unit_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero
  );
endinterface

// File: rtl/shift_rotate_unit_step.sv
// One combinational step of the unit: applies the op by k (0..STEP) positions
// and reports the last bit shifted out or wrapped around.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [2:0]       op_i,
  input  logic [KW-1:0]    k_i,
  output logic [WIDTH-1:0] y_o,
  output logic             carry_o
);

  logic [2*WIDTH-1:0] dbl_l_s;
  logic [2*WIDTH-1:0] dbl_r_s;
  logic [WIDTH:0]     ext_l_s;
  logic [WIDTH:0]     ext_r_s;

  // Doubled operand turns rotates into plain shifts; the one-bit extensions
  // catch the bit that falls off the end of a logical/arithmetic shift.
  assign dbl_l_s = {x_i, x_i} << k_i;
  assign dbl_r_s = {x_i, x_i} >> k_i;
  assign ext_l_s = {1'b0, x_i} << k_i;
  assign ext_r_s = {x_i, 1'b0} >> k_i;

  // Result and carry selection per operation
  always_comb begin
    y_o     = x_i;
    carry_o = 1'b0;
    case (op_i)
      OP_ROL: begin
        y_o     = dbl_l_s[2*WIDTH-1:WIDTH];
        carry_o = dbl_l_s[WIDTH];
      end
      OP_ROR: begin
        y_o     = dbl_r_s[WIDTH-1:0];
        carry_o = dbl_r_s[WIDTH-1];
      end
      OP_SLL: begin
        y_o     = x_i << k_i;
        carry_o = ext_l_s[WIDTH];
      end
      OP_SRL: begin
        y_o     = x_i >> k_i;
        carry_o = ext_r_s[0];
      end
      OP_SRA: begin
        y_o     = $signed(x_i) >>> k_i;
        carry_o = ext_r_s[0];
      end
      default: begin
        y_o     = x_i;
        carry_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit: IDLE/BUSY/DONE FSM, remaining-amount counter and
// working registers around a single shift_step instance.
module shift_rotate_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input logic               clk,
  input logic               rst_n,
  shift_rotate_unit_if.slave bus
);

  localparam int KW = $clog2(STEP + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic             accept_s;
  logic             skip_s;
  logic [KW-1:0]    k_s;
  logic [AMT_W-1:0] rem_next_s;
  logic [WIDTH-1:0] step_data_s;
  logic             step_carry_s;

  assign accept_s   = bus.in_valid && (state_q == S_IDLE);
  assign skip_s     = (bus.in_amt == {AMT_W{1'b0}}) || is_pass(bus.in_op);
  // k never exceeds rem, so narrowing k to AMT_W bits is lossless
  assign rem_next_s = rem_q - AMT_W'(k_s);

  // Step size: min(STEP, remaining amount)
  always_comb begin
    if (int'(rem_q) < STEP) begin
      k_s = KW'(rem_q);
    end else begin
      k_s = KW'(STEP);
    end
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .x_i     (data_q),
    .op_i    (op_q),
    .k_i     (k_s),
    .y_o     (step_data_s),
    .carry_o (step_carry_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = skip_s ? S_DONE : S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (rem_next_s == {AMT_W{1'b0}}) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Working-register next values
  always_comb begin
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          data_d  = bus.in_data;
          op_d    = bus.in_op;
          rem_d   = skip_s ? {AMT_W{1'b0}} : bus.in_amt;
          carry_d = 1'b0;
        end else begin
          data_d  = data_q;
        end
      end
      S_BUSY: begin
        data_d  = step_data_s;
        carry_d = step_carry_s;
        rem_d   = rem_next_s;
      end
      S_DONE:  data_d = data_q;
      default: data_d = data_q;
    endcase
  end

  // Zero flag is captured only on the transition into DONE
  always_comb begin
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      zero_d = (data_d == {WIDTH{1'b0}});
    end else begin
      zero_d = zero_q;
    end
  end

  // Working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= {WIDTH{1'b0}};
      op_q    <= 3'b000;
      rem_q   <= {AMT_W{1'b0}};
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // FSM outputs, all driven from registers
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
    bus.out_data  = data_q;
    bus.out_carry = carry_q;
    bus.out_zero  = zero_q;
  end

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed bench for shift_rotate_unit (WIDTH=16, STEP=4) with hand-computed results.
module tb_shift_rotate_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  shift_rotate_unit_if #(.WIDTH(16), .AMT_W(4)) bus ();

  shift_rotate_unit #(.WIDTH(16), .STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [2:0] op, input logic [15:0] d,
                       input logic [3:0] a);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = d;
    bus.in_amt   = a;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat = 1;
    while (!bus.out_valid && lat < 40) begin
      chk({tag, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic check_out(input string tag, input logic [15:0] d, input logic c,
                           input logic z);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
    chk({tag, "_carry"}, 32'(bus.out_carry), 32'(c));
    chk({tag, "_zero"}, 32'(bus.out_zero), 32'(z));
    chk({tag, "_done_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_rel_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_rel_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'b000;
    bus.in_data   = 16'h0000;
    bus.in_amt    = 4'd0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_carry", 32'(bus.out_carry), 32'd0);
    chk("rst_zero", 32'(bus.out_zero), 32'd0);
    rst_n = 1'b1;

    issue("rol1", 3'b000, 16'h8001, 4'd1);
    wait_result("rol1", 2);
    check_out("rol1", 16'h0003, 1'b1, 1'b0);
    release_out("rol1");

    issue("ror4", 3'b001, 16'h1234, 4'd4);
    wait_result("ror4", 2);
    check_out("ror4", 16'h4123, 1'b0, 1'b0);
    release_out("ror4");

    issue("sra15", 3'b100, 16'h8000, 4'd15);
    wait_result("sra15", 5);
    check_out("sra15", 16'hFFFF, 1'b0, 1'b0);
    release_out("sra15");

    issue("sll12", 3'b010, 16'h00FF, 4'd12);
    wait_result("sll12", 4);
    check_out("sll12", 16'hF000, 1'b1, 1'b0);
    release_out("sll12");

    issue("srl1", 3'b011, 16'h0001, 4'd1);
    wait_result("srl1", 2);
    check_out("srl1", 16'h0000, 1'b1, 1'b1);
    release_out("srl1");

    issue("amt0", 3'b000, 16'hABCD, 4'd0);
    wait_result("amt0", 1);
    check_out("amt0", 16'hABCD, 1'b0, 1'b0);
    release_out("amt0");

    issue("pass", 3'b111, 16'hABCD, 4'd5);
    wait_result("pass", 1);
    check_out("pass", 16'hABCD, 1'b0, 1'b0);
    release_out("pass");

    // Backpressure: result must hold while a competing request is offered
    issue("bp", 3'b000, 16'h8001, 4'd1);
    wait_result("bp", 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_op    = 3'b010;
      bus.in_data  = 16'h5555;
      bus.in_amt   = 4'd3;
      check_out("bp_hold", 16'h0003, 1'b1, 1'b0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_out("bp_end", 16'h0003, 1'b1, 1'b0);
    release_out("bp");

    // Asynchronous reset while BUSY aborts the operation
    issue("abort", 3'b011, 16'hFFFF, 4'd15);
    @(posedge clk);
    #2;
    chk("abort_busy_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_data", 32'(bus.out_data), 32'd0);
    chk("abort_carry", 32'(bus.out_carry), 32'd0);
    chk("abort_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    issue("post", 3'b000, 16'h0001, 4'd2);
    wait_result("post", 2);
    check_out("post", 16'h0004, 1'b0, 1'b0);
    release_out("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_rotate_unit.md
Name: shift_rotate_unit

Overview:
- Multi-cycle, parametrised shift/rotate execution unit for the ALU datapath.
- Supersedes the single-cycle 16-bit rotator with five operations: ROL, ROR, SLL, SRL and SRA.
- Processes STEP bit positions per cycle, trading latency for area.
- Reports carry-out and zero flags, and uses valid/ready handshakes on both input and output so the control unit can stall on it.

Parameters:
- WIDTH, 16: operand/result width in bits. Must be ≥ 2.
- STEP, 4: maximum bit positions shifted per BUSY cycle. Legal range 1..WIDTH.
- AMT_W, $clog2(WIDTH): width of the shift amount (derived; do not override).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- in_data  in  WIDTH  operand.
- in_amt  in  AMT_W  shift amount, 0..WIDTH-1.
- in_op  in  3  operation code: 000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, others PASS.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.
- out_carry  out  1  last bit shifted out, or last bit wrapped.
- out_zero  out  1  out_data == 0.

Behaviour:
- Clocking and reset: single clock domain; reset is asynchronous and active-low (rst_n). Reset drives the FSM to IDLE, out_valid=0, out_data=0, out_carry=0, out_zero=0, remaining count=0. in_ready=1 after reset.
- FSM states: IDLE, BUSY, DONE.
- in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE: on in_valid && in_ready, latch in_data, in_op and in_amt into working registers, and clear carry.
  - If in_amt==0 or in_op is PASS: go to DONE with data unchanged, carry=0.
  - Otherwise go to BUSY with rem=in_amt.
- BUSY, each cycle: k = min(STEP, rem). Apply op by k to the working register; rem -= k. When rem becomes 0, go to DONE.
- Per-step results (x is the working value at the start of the step):
  - ROL: x rotl k, carry = new bit0.
  - ROR: x rotr k, carry = new bit WIDTH-1.
  - SLL: x<<k zero-filled, carry = x[WIDTH-k].
  - SRL: x>>k zero-filled, carry = x[k-1].
  - SRA: same as SRL but sign-filled from x[WIDTH-1].
- Latency from the accept edge to out_valid:
  - 1 cycle for amt==0 or PASS.
  - Otherwise 1 + ceil(amt/STEP) cycles.
  - Example (WIDTH=16, STEP=4, amt=15): 5 cycles.
- DONE: out_data, out_carry and out_zero are stable while out_valid=1. On out_ready, go to IDLE.
  - No same-cycle re-accept: in_ready asserts in the cycle after the handshake. Throughput is therefore ≤ 1 op per (latency+1) cycles.
- out_ready is ignored outside DONE.
- in_valid and input data are ignored outside IDLE; inputs are not re-sampled while BUSY.
- out_zero is computed from the final data as it enters DONE (registered).
- Reset asserted in BUSY or DONE aborts the operation immediately; no result is produced.
- Amount width: AMT_W cannot express WIDTH, so a full-width shift is not supported. The decoder must supply 0..WIDTH-1.
- STEP==WIDTH: every nonzero amount completes in exactly one BUSY cycle.

Decomposition:
- Shared package shift_pkg holds:
  - the op-code localparams OP_ROL, OP_ROR, OP_SLL, OP_SRL, OP_SRA;
  - the FSM state encoding S_IDLE, S_BUSY, S_DONE.
- One combinational sub-module, shift_step: inputs x, op and k (0..STEP); outputs the shifted value and the carry.
  - Instantiated once, fed from the working registers.
  - Covers all five ops, so the top module is only the FSM, counter and registers.

Test Plan (WIDTH=16, STEP=4):
- ROL 0x8001 by 1 -> out_data=0x0003, carry=1, zero=0; out_valid 2 cycles after accept.
- ROR 0x1234 by 4 -> 0x4123, carry=0. SRA 0x8000 by 15 -> 0xFFFF, carry=0; latency 5 cycles.
- SLL 0x00FF by 12 -> 0xF000, carry=1. SRL 0x0001 by 1 -> 0x0000, carry=1, zero=1.
- amt=0 (ROL 0xABCD) and op=111 (PASS) -> 0xABCD, carry=0, out_valid 1 cycle after accept; in_ready low meanwhile.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> out_* stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE, in_ready=1 the next cycle.
- Reset mid-operation: pulse rst_n low during BUSY of SRL 0xFFFF by 15 -> out_valid=0, out_data=0 immediately (async). After release, an ROL 0x0001 by 2 request returns 0x0004.
